// File: rtl/axi_arb_pkg.sv
// Shared types and defaults for the AW/W many-to-one arbiter.
// Build option AXI_ARB_AW_ROUND_ROBIN_EN is consumed by axi_arbiter_mtos_aw.
package axi_arb_pkg;

    localparam int unsigned NumDefault   = 3;
    localparam int unsigned DepthDefault = 4;

    typedef enum logic {
        StRun,
        StHold
    } aw_state_e;

endpackage

// File: rtl/axi_arbiter_mtos_aw_if.sv
// Arbitration request/grant bundle between NUM+1 AXI masters and one slave port.
// The master modport drives requests; the slave modport is the arbiter.
interface axi_arbiter_mtos_aw_if
    import axi_arb_pkg::*;
#(
    parameter int unsigned NUM = NumDefault
);

    logic [NUM:0] AWSELECT;
    logic [NUM:0] AWVALID;
    logic         AWREADY;
    logic [NUM:0] AWGRANT;
    logic [NUM:0] WVALID;
    logic [NUM:0] WLAST;
    logic         WREADY;
    logic [NUM:0] WGRANT;

    modport master (
        output AWSELECT, AWVALID, AWREADY, WVALID, WLAST, WREADY,
        input  AWGRANT, WGRANT
    );

    modport slave (
        input  AWSELECT, AWVALID, AWREADY, WVALID, WLAST, WREADY,
        output AWGRANT, WGRANT
    );

endinterface

// File: rtl/axi_arb_order_fifo.sv
// Order FIFO of granted master indices: one entry per AW accepted, retired on the
// final W beat. Synchronous active-high reset.
module axi_arb_order_fifo #(
    parameter int unsigned IdxW  = 2,
    parameter int unsigned Depth = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [IdxW-1:0] idx_i,
    output logic [IdxW-1:0] idx_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth) + 1;

    logic [IdxW-1:0] mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign idx_o   = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read while counted.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= idx_i;
    end

endmodule

// File: rtl/axi_arbiter_mtos_aw.sv
// Many-to-one AW arbiter with W routing in AW acceptance order.
// Define AXI_ARB_AW_ROUND_ROBIN_EN for round-robin pick; default is fixed priority.
module axi_arbiter_mtos_aw
    import axi_arb_pkg::*;
#(
    parameter int unsigned NUM   = NumDefault,
    parameter int unsigned DEPTH = DepthDefault
) (
    input logic                  ACLK,
    input logic                  ARESET,
    axi_arbiter_mtos_aw_if.slave bus
);

    localparam int unsigned N    = NUM + 1;
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

    aw_state_e       state_q, state_d;
    logic [NUM:0]    gnt_q, gnt_d;
    logic [NUM:0]    aw_req, pick_oh, aw_grant, w_grant;
    logic            pick_vld, aw_hs, w_last_beat;
    logic [IdxW-1:0] aw_idx, head_idx;
    logic            fifo_full, fifo_empty;

    assign aw_req = bus.AWSELECT & bus.AWVALID;

`ifdef AXI_ARB_AW_ROUND_ROBIN_EN
    logic [IdxW-1:0] ptr_q, ptr_d;
    int unsigned     rr_k;

    always_comb begin
        pick_oh  = '0;
        pick_vld = 1'b0;
        rr_k     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            rr_k = 32'(ptr_q) + i;
            if (rr_k >= N) rr_k = rr_k - N;
            if (!pick_vld && aw_req[rr_k]) begin
                pick_vld       = 1'b1;
                pick_oh[rr_k]  = 1'b1;
            end
        end
    end

    assign ptr_d = !aw_hs ? ptr_q : (aw_idx == IdxW'(NUM)) ? '0 : aw_idx + IdxW'(1);

    always_ff @(posedge ACLK) begin
        if (ARESET) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    always_comb begin
        pick_oh  = '0;
        pick_vld = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!pick_vld && aw_req[i]) begin
                pick_vld   = 1'b1;
                pick_oh[i] = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        aw_grant = '0;
        unique case (state_q)
            StRun: begin
                // Full is the registered count, so a same-cycle pop cannot unblock.
                if (pick_vld && !fifo_full) aw_grant = pick_oh;
            end
            StHold: aw_grant = gnt_q;
            default: aw_grant = '0;
        endcase
        if (ARESET) aw_grant = '0;
        aw_hs = |(aw_grant & bus.AWVALID) & bus.AWREADY;
        if (state_q == StRun && |aw_grant && !aw_hs) begin
            state_d = StHold;
            gnt_d   = aw_grant;
        end else if (state_q == StHold && aw_hs) begin
            state_d = StRun;
            gnt_d   = '0;
        end
    end

    always_comb begin
        aw_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (aw_grant[i]) aw_idx = IdxW'(i);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= StRun;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
        end
    end

    always_comb begin
        w_grant = '0;
        if (!fifo_empty && !ARESET) w_grant[head_idx] = 1'b1;
    end

    assign w_last_beat = |(w_grant & bus.WVALID) & bus.WREADY & |(w_grant & bus.WLAST);

    axi_arb_order_fifo #(
        .IdxW  (IdxW),
        .Depth (DEPTH)
    ) u_order_fifo (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .push_i  (aw_hs),
        .pop_i   (w_last_beat),
        .idx_i   (aw_idx),
        .idx_o   (head_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.AWGRANT = aw_grant;
    assign bus.WGRANT  = w_grant;

endmodule

// File: tb/tb_axi_arbiter_mtos_aw.sv
// Directed self-checking bench for axi_arbiter_mtos_aw (NUM=3, DEPTH=4); expectations
// follow the round-robin pick when AXI_ARB_AW_ROUND_ROBIN_EN is defined.
module tb_axi_arbiter_mtos_aw;
    import axi_arb_pkg::*;

`ifdef AXI_ARB_AW_ROUND_ROBIN_EN
    localparam bit Rr = 1'b1;
`else
    localparam bit Rr = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    axi_arbiter_mtos_aw_if #(.NUM(3)) bus ();

    axi_arbiter_mtos_aw #(
        .NUM   (3),
        .DEPTH (4)
    ) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] sel, input logic [3:0] awv, input logic awr,
                         input logic [3:0] wv, input logic [3:0] wl, input logic wr);
        bus.AWSELECT = sel;
        bus.AWVALID  = awv;
        bus.AWREADY  = awr;
        bus.WVALID   = wv;
        bus.WLAST    = wl;
        bus.WREADY   = wr;
        #2;
    endtask

    // Next edge, then a small offset so inputs change away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset: grants forced low even with every request active
        rst = 1'b1;
        drive(4'b1111, 4'b1111, 1'b1, 4'b1111, 4'b1111, 1'b1);
        tick();
        drive(4'b1111, 4'b1111, 1'b1, 4'b1111, 4'b1111, 1'b1);
        check_eq("rst_awgrant", bus.AWGRANT, 4'b0000);
        check_eq("rst_wgrant", bus.WGRANT, 4'b0000);
        rst = 1'b0;

        // AWREQ = AWSELECT & AWVALID = 0101
        do_reset();
        drive(4'b0101, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0);
        check_eq("req_first", bus.AWGRANT, 4'b0001);
        tick();
        drive(4'b0101, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0);
        check_eq("req_second", bus.AWGRANT, Rr ? 4'b0100 : 4'b0001);
        check_eq("req_w_after_push", bus.WGRANT, 4'b0001);

        // Stall: grant held through AWREADY=0 regardless of request changes
        do_reset();
        drive(4'b1111, 4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0);
        check_eq("stall_run", bus.AWGRANT, 4'b0010);
        tick();
        drive(4'b1111, 4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0);
        check_eq("stall_hold1", bus.AWGRANT, 4'b0010);
        tick();
        drive(4'b1111, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0);
        check_eq("stall_hold_req_chg", bus.AWGRANT, 4'b0010);
        tick();
        drive(4'b1111, 4'b1010, 1'b0, 4'b0000, 4'b0000, 1'b0);
        check_eq("stall_hold_1010", bus.AWGRANT, 4'b0010);
        check_eq("stall_no_w", bus.WGRANT, 4'b0000);
        tick();
        drive(4'b1111, 4'b1010, 1'b1, 4'b0000, 4'b0000, 1'b0);
        check_eq("stall_hs", bus.AWGRANT, 4'b0010);
        tick();
        drive(4'b1111, 4'b1010, 1'b0, 4'b0000, 4'b0000, 1'b0);
        check_eq("stall_after_hs", bus.AWGRANT, Rr ? 4'b1000 : 4'b0010);
        check_eq("stall_w", bus.WGRANT, 4'b0010);

        // W ordering: AW from 2 then 0
        do_reset();
        drive(4'b1111, 4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b0);
        check_eq("ord_aw2", bus.AWGRANT, 4'b0100);
        check_eq("ord_w_empty", bus.WGRANT, 4'b0000);
        tick();
        drive(4'b1111, 4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b0);
        check_eq("ord_aw0", bus.AWGRANT, 4'b0001);
        check_eq("ord_w2_latency", bus.WGRANT, 4'b0100);
        tick();
        drive(4'b1111, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b1);
        check_eq("ord_w2_beat", bus.WGRANT, 4'b0100);
        tick();
        drive(4'b1111, 4'b0000, 1'b0, 4'b0100, 4'b0100, 1'b1);
        check_eq("ord_w2_last", bus.WGRANT, 4'b0100);
        tick();
        drive(4'b1111, 4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b1);
        check_eq("ord_w0", bus.WGRANT, 4'b0001);
        tick();
        drive(4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        check_eq("ord_drained", bus.WGRANT, 4'b0000);

        // Full FIFO blocks AW; pop only unblocks on the following cycle
        do_reset();
        drive(4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0);
        check_eq("full_aw1", bus.AWGRANT, 4'b0001);
        tick();
        drive(4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0);
        check_eq("full_aw2", bus.AWGRANT, Rr ? 4'b0010 : 4'b0001);
        tick();
        drive(4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0);
        check_eq("full_aw3", bus.AWGRANT, Rr ? 4'b0100 : 4'b0001);
        tick();
        drive(4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0);
        check_eq("full_aw4", bus.AWGRANT, Rr ? 4'b1000 : 4'b0001);
        tick();
        drive(4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0);
        check_eq("full_blocked", bus.AWGRANT, 4'b0000);
        tick();
        drive(4'b1111, 4'b1111, 1'b1, 4'b1111, 4'b1111, 1'b1);
        check_eq("full_pop_same_cycle", bus.AWGRANT, 4'b0000);
        check_eq("full_w_head", bus.WGRANT, 4'b0001);
        tick();
        drive(4'b1111, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0);
        check_eq("full_unblocked", bus.AWGRANT, 4'b0001);
        check_eq("full_w_next", bus.WGRANT, Rr ? 4'b0010 : 4'b0001);

        // Reset during HOLD with two entries queued
        do_reset();
        drive(4'b1111, 4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b0);
        tick();
        drive(4'b1111, 4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b0);
        tick();
        drive(4'b1111, 4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0);
        tick();
        drive(4'b1111, 4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0);
        check_eq("mid_hold", bus.AWGRANT, 4'b0010);
        check_eq("mid_w_head", bus.WGRANT, 4'b0001);
        rst = 1'b1;
        drive(4'b1111, 4'b0010, 1'b0, 4'b0000, 4'b0000, 1'b0);
        check_eq("mid_rst_aw", bus.AWGRANT, 4'b0000);
        check_eq("mid_rst_w", bus.WGRANT, 4'b0000);
        tick();
        rst = 1'b0;
        drive(4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
        check_eq("post_rst_aw", bus.AWGRANT, 4'b0000);
        check_eq("post_rst_w", bus.WGRANT, 4'b0000);
        drive(4'b1111, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0);
        check_eq("post_rst_ptr", bus.AWGRANT, 4'b0001);
        drive(4'b1111, 4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b0);
        check_eq("post_rst_no_hold", bus.AWGRANT, 4'b0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
